// File: rtl/rggen_trigger_handshake_pkg.sv
// ============================================================================
// Module   : rggen_trigger_handshake_pkg
// Purpose  : State encoding and sizing helpers for the trigger handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rggen_trigger_handshake_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_QUEUED = 2'd2
    } state_e;

    // Counter must be able to hold 0..TIMEOUT_CYCLES; a 1-bit stub when disabled.
    function automatic int calc_count_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rggen_trigger_handshake_channel.sv
// ============================================================================
// Module   : rggen_trigger_handshake_channel
// Purpose  : One trigger channel: request FSM with one-deep queue, optional
//            timeout counter and sticky overflow/timeout flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_trigger_handshake_channel
    import rggen_trigger_handshake_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trigger,
    input  logic i_ack,
    input  logic i_clear_overflow,
    input  logic i_clear_timeout,
    output logic o_req,
    output logic o_start,
    output logic o_pending,
    output logic o_overflow,
    output logic o_timeout
);

    state_e r_state;
    state_e w_next_state;
    logic   r_req;
    logic   r_start;
    logic   r_pending;
    logic   r_overflow;
    logic   r_timeout;
    logic   w_start;
    logic   w_count_clear;
    logic   w_set_overflow;
    logic   w_done;
    logic   w_timeout_hit;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int c_count_width = calc_count_width(TIMEOUT_CYCLES);
            localparam logic [c_count_width-1:0] c_count_last =
                c_count_width'(TIMEOUT_CYCLES - 1);

            logic [c_count_width-1:0] r_count;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_count <= '0;
                end else if (w_count_clear) begin
                    r_count <= '0;
                end else if (r_req && !i_ack) begin
                    r_count <= r_count + c_count_width'(1);
                end
            end

            // An ack in the final cycle takes priority over abandoning the operation.
            assign w_timeout_hit = r_req && !i_ack && (r_count == c_count_last);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next_state   = r_state;
        w_start        = 1'b0;
        w_count_clear  = 1'b0;
        w_set_overflow = 1'b0;
        w_done         = i_ack || w_timeout_hit;

        case (r_state)
            ST_IDLE: begin
                if (i_trigger) begin
                    w_next_state  = ST_BUSY;
                    w_start       = 1'b1;
                    w_count_clear = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_done && i_trigger) begin
                    w_start       = 1'b1;
                    w_count_clear = 1'b1;
                end else if (w_done) begin
                    w_next_state  = ST_IDLE;
                    w_count_clear = 1'b1;
                end else if (i_trigger) begin
                    w_next_state  = ST_QUEUED;
                end
            end
            ST_QUEUED: begin
                // Finishing an operation launches the queued one; a coincident
                // trigger refills the queue slot instead of overflowing.
                if (w_done) begin
                    w_start       = 1'b1;
                    w_count_clear = 1'b1;
                    if (!i_trigger) begin
                        w_next_state = ST_BUSY;
                    end
                end else if (i_trigger) begin
                    w_set_overflow = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_start    <= 1'b0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_req      <= (w_next_state != ST_IDLE);
            r_pending  <= (w_next_state == ST_QUEUED);
            r_start    <= w_start;
            r_overflow <= w_set_overflow | (r_overflow & ~i_clear_overflow);
            r_timeout  <= w_timeout_hit  | (r_timeout  & ~i_clear_timeout);
        end
    end

    assign o_req      = r_req;
    assign o_start    = r_start;
    assign o_pending  = r_pending;
    assign o_overflow = r_overflow;
    assign o_timeout  = r_timeout;

endmodule

`default_nettype wire

// File: rtl/rggen_trigger_handshake.sv
// ============================================================================
// Module   : rggen_trigger_handshake
// Purpose  : Turns trigger-field pulses into held requests to a slow target,
//            one independent channel per trigger bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_trigger_handshake
    import rggen_trigger_handshake_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_trigger,
    input  logic [WIDTH-1:0] i_ack,
    input  logic [WIDTH-1:0] i_clear_overflow,
    input  logic [WIDTH-1:0] i_clear_timeout,
    output logic [WIDTH-1:0] o_req,
    output logic [WIDTH-1:0] o_start,
    output logic [WIDTH-1:0] o_pending,
    output logic [WIDTH-1:0] o_overflow,
    output logic [WIDTH-1:0] o_timeout
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_channel
            rggen_trigger_handshake_channel #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_channel (
                .i_clk            (i_clk),
                .i_rst_n          (i_rst_n),
                .i_trigger        (i_trigger[i]),
                .i_ack            (i_ack[i]),
                .i_clear_overflow (i_clear_overflow[i]),
                .i_clear_timeout  (i_clear_timeout[i]),
                .o_req            (o_req[i]),
                .o_start          (o_start[i]),
                .o_pending        (o_pending[i]),
                .o_overflow       (o_overflow[i]),
                .o_timeout        (o_timeout[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rggen_trigger_handshake.sv
// ============================================================================
// Module   : tb_rggen_trigger_handshake
// Purpose  : Directed scoreboard bench; one DUT without and one with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rggen_trigger_handshake;

    localparam int S_REQ = 0, S_START = 1, S_PEND = 2, S_OVF = 3, S_TO = 4;

    typedef struct {
        int         cyc;
        int         dut;
        int         sel;
        logic [7:0] mask;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] trig, ack, clr_ovf, clr_to;
    logic [7:0] req0, start0, pend0, ovf0, to0;
    logic [7:0] req4, start4, pend4, ovf4, to4;

    int   g = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    rggen_trigger_handshake #(.WIDTH(8), .TIMEOUT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_trigger(trig), .i_ack(ack),
        .i_clear_overflow(clr_ovf), .i_clear_timeout(clr_to),
        .o_req(req0), .o_start(start0), .o_pending(pend0),
        .o_overflow(ovf0), .o_timeout(to0)
    );

    rggen_trigger_handshake #(.WIDTH(8), .TIMEOUT_CYCLES(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_trigger(trig), .i_ack(ack),
        .i_clear_overflow(clr_ovf), .i_clear_timeout(clr_to),
        .o_req(req4), .o_start(start4), .o_pending(pend4),
        .o_overflow(ovf4), .o_timeout(to4)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) g <= g + 1;

    function automatic logic [7:0] get(input int d, input int s);
        logic [7:0] v;
        v = 8'h00;
        case (s)
            S_REQ:   v = (d == 0) ? req0   : req4;
            S_START: v = (d == 0) ? start0 : start4;
            S_PEND:  v = (d == 0) ? pend0  : pend4;
            S_OVF:   v = (d == 0) ? ovf0   : ovf4;
            S_TO:    v = (d == 0) ? to0    : to4;
            default: v = 8'hxx;
        endcase
        return v;
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= g) begin
                n_checks++;
                if (sb[i].cyc < g) begin
                    n_errors++;
                    $display("FAIL %s: not sampled in cycle %0d (now %0d)", sb[i].name, sb[i].cyc, g);
                end else begin
                    act = get(sb[i].dut, sb[i].sel) & sb[i].mask;
                    if (act !== sb[i].val) begin
                        n_errors++;
                        $display("FAIL %s: got %02h expected %02h (cycle %0d)",
                                 sb[i].name, act, sb[i].val, g - t0);
                    end
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int n);
        while (g - t0 < n) tick();
    endtask

    task automatic expect_at(input int n, input int d, input int s,
                             input logic [7:0] m, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc = t0 + n; e.dut = d; e.sel = s; e.mask = m; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input int n, input logic [7:0] t, input logic [7:0] a,
                         input logic [7:0] co, input logic [7:0] ct);
        at(n);
        trig = t; ack = a; clr_ovf = co; clr_to = ct;
        at(n + 1);
        trig = '0; ack = '0; clr_ovf = '0; clr_to = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        trig = '0; ack = '0; clr_ovf = '0; clr_to = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        t0 = g;
    endtask

    initial begin
        rst_n = 1'b0;
        trig = '0; ack = '0; clr_ovf = '0; clr_to = '0;

        // 1: reset state and single operation on channel 3
        apply_reset();
        expect_at(1, 0, S_REQ,   8'hff, 8'h00, "rst_req");
        expect_at(1, 0, S_START, 8'hff, 8'h00, "rst_start");
        expect_at(1, 0, S_PEND,  8'hff, 8'h00, "rst_pend");
        expect_at(1, 0, S_OVF,   8'hff, 8'h00, "rst_ovf");
        expect_at(1, 1, S_TO,    8'hff, 8'h00, "rst_to_t4");
        expect_at(5, 0, S_REQ,   8'hff, 8'h00, "t1_req_c5");
        expect_at(6, 0, S_REQ,   8'hff, 8'h08, "t1_req_c6");
        expect_at(6, 0, S_START, 8'hff, 8'h08, "t1_start_c6");
        expect_at(7, 0, S_START, 8'hff, 8'h00, "t1_start_c7");
        expect_at(10, 0, S_REQ,  8'hff, 8'h08, "t1_req_c10");
        expect_at(11, 0, S_REQ,  8'hff, 8'h00, "t1_req_c11");
        drive(5, 8'h08, 8'h00, 8'h00, 8'h00);
        drive(10, 8'h00, 8'h08, 8'h00, 8'h00);
        at(13);

        // 2: queued second trigger, back-to-back operations
        apply_reset();
        expect_at(6, 0, S_START, 8'h01, 8'h01, "t2_start_c6");
        expect_at(7, 0, S_PEND,  8'h01, 8'h00, "t2_pend_c7");
        expect_at(8, 0, S_PEND,  8'h01, 8'h01, "t2_pend_c8");
        expect_at(9, 0, S_PEND,  8'h01, 8'h01, "t2_pend_c9");
        expect_at(10, 0, S_PEND, 8'h01, 8'h00, "t2_pend_c10");
        expect_at(10, 0, S_START, 8'h01, 8'h01, "t2_start_c10");
        expect_at(10, 0, S_REQ,  8'h01, 8'h01, "t2_req_c10");
        expect_at(11, 0, S_START, 8'h01, 8'h00, "t2_start_c11");
        expect_at(12, 0, S_REQ,  8'h01, 8'h01, "t2_req_c12");
        expect_at(13, 0, S_REQ,  8'h01, 8'h00, "t2_req_c13");
        expect_at(13, 0, S_OVF,  8'h01, 8'h00, "t2_ovf_c13");
        drive(5, 8'h01, 8'h00, 8'h00, 8'h00);
        drive(7, 8'h01, 8'h00, 8'h00, 8'h00);
        drive(9, 8'h00, 8'h01, 8'h00, 8'h00);
        drive(12, 8'h00, 8'h01, 8'h00, 8'h00);
        at(15);

        // 3: overflow, set-wins-over-clear, then clear
        apply_reset();
        expect_at(7, 0, S_OVF,   8'h02, 8'h00, "t3_ovf_c7");
        expect_at(8, 0, S_OVF,   8'h02, 8'h02, "t3_ovf_c8");
        expect_at(8, 0, S_PEND,  8'h02, 8'h02, "t3_pend_c8");
        expect_at(21, 0, S_OVF,  8'h02, 8'h02, "t3_ovf_setwins");
        expect_at(22, 0, S_OVF,  8'h02, 8'h02, "t3_ovf_c22");
        expect_at(23, 0, S_OVF,  8'h02, 8'h00, "t3_ovf_cleared");
        drive(5, 8'h02, 8'h00, 8'h00, 8'h00);
        drive(6, 8'h02, 8'h00, 8'h00, 8'h00);
        drive(7, 8'h02, 8'h00, 8'h00, 8'h00);
        drive(20, 8'h02, 8'h00, 8'h02, 8'h00);
        drive(22, 8'h00, 8'h00, 8'h02, 8'h00);
        at(25);

        // 4a: timeout from BUSY, then clear
        apply_reset();
        expect_at(5, 1, S_REQ,   8'h04, 8'h00, "t4a_req_c5");
        expect_at(6, 1, S_REQ,   8'h04, 8'h04, "t4a_req_c6");
        expect_at(9, 1, S_REQ,   8'h04, 8'h04, "t4a_req_c9");
        expect_at(9, 1, S_TO,    8'h04, 8'h00, "t4a_to_c9");
        expect_at(10, 1, S_REQ,  8'h04, 8'h00, "t4a_req_c10");
        expect_at(10, 1, S_TO,   8'h04, 8'h04, "t4a_to_c10");
        expect_at(13, 1, S_TO,   8'h04, 8'h00, "t4a_to_cleared");
        drive(5, 8'h04, 8'h00, 8'h00, 8'h00);
        drive(12, 8'h00, 8'h00, 8'h00, 8'h04);
        at(15);

        // 4b: ack in the last allowed cycle wins
        apply_reset();
        expect_at(9, 1, S_REQ,   8'h04, 8'h04, "t4b_req_c9");
        expect_at(10, 1, S_REQ,  8'h04, 8'h00, "t4b_req_c10");
        expect_at(10, 1, S_TO,   8'h04, 8'h00, "t4b_to_c10");
        expect_at(11, 1, S_TO,   8'h04, 8'h00, "t4b_to_c11");
        drive(5, 8'h04, 8'h00, 8'h00, 8'h00);
        drive(9, 8'h00, 8'h04, 8'h00, 8'h00);
        at(13);

        // 4c: timeout in QUEUED starts the queued operation
        apply_reset();
        expect_at(9, 1, S_PEND,  8'h04, 8'h04, "t4c_pend_c9");
        expect_at(10, 1, S_REQ,  8'h04, 8'h04, "t4c_req_c10");
        expect_at(10, 1, S_START, 8'h04, 8'h04, "t4c_start_c10");
        expect_at(10, 1, S_PEND, 8'h04, 8'h00, "t4c_pend_c10");
        expect_at(10, 1, S_TO,   8'h04, 8'h04, "t4c_to_c10");
        expect_at(13, 1, S_REQ,  8'h04, 8'h04, "t4c_req_c13");
        expect_at(14, 1, S_REQ,  8'h04, 8'h00, "t4c_req_c14");
        drive(5, 8'h04, 8'h00, 8'h00, 8'h00);
        drive(6, 8'h04, 8'h00, 8'h00, 8'h00);
        at(16);

        // 4d: trigger in the timeout cycle restarts like an ack+trigger
        apply_reset();
        expect_at(10, 1, S_REQ,  8'h04, 8'h04, "t4d_req_c10");
        expect_at(10, 1, S_START, 8'h04, 8'h04, "t4d_start_c10");
        expect_at(10, 1, S_PEND, 8'h04, 8'h00, "t4d_pend_c10");
        expect_at(10, 1, S_TO,   8'h04, 8'h04, "t4d_to_c10");
        drive(5, 8'h04, 8'h00, 8'h00, 8'h00);
        drive(9, 8'h04, 8'h00, 8'h00, 8'h00);
        at(12);

        // 5: ack+trigger in BUSY, then in QUEUED
        apply_reset();
        expect_at(8, 0, S_REQ,   8'h10, 8'h10, "t5_req_c8");
        expect_at(9, 0, S_REQ,   8'h10, 8'h10, "t5_req_c9");
        expect_at(9, 0, S_START, 8'h10, 8'h10, "t5_start_c9");
        expect_at(9, 0, S_PEND,  8'h10, 8'h00, "t5_pend_c9");
        expect_at(10, 0, S_START, 8'h10, 8'h00, "t5_start_c10");
        expect_at(11, 0, S_PEND, 8'h10, 8'h10, "t5_pend_c11");
        expect_at(14, 0, S_REQ,  8'h10, 8'h10, "t5_req_c14");
        expect_at(14, 0, S_START, 8'h10, 8'h10, "t5_start_c14");
        expect_at(14, 0, S_PEND, 8'h10, 8'h10, "t5_pend_c14");
        expect_at(14, 0, S_OVF,  8'h10, 8'h00, "t5_ovf_c14");
        drive(5, 8'h10, 8'h00, 8'h00, 8'h00);
        drive(8, 8'h10, 8'h10, 8'h00, 8'h00);
        drive(10, 8'h10, 8'h00, 8'h00, 8'h00);
        drive(13, 8'h10, 8'h10, 8'h00, 8'h00);
        at(16);

        // 6: asynchronous reset while two channels are QUEUED
        apply_reset();
        expect_at(8, 0, S_PEND,  8'hff, 8'h60, "t6_pend_c8");
        expect_at(9, 0, S_REQ,   8'hff, 8'h00, "t6_async_req");
        expect_at(9, 0, S_PEND,  8'hff, 8'h00, "t6_async_pend");
        expect_at(9, 0, S_START, 8'hff, 8'h00, "t6_async_start");
        expect_at(9, 0, S_OVF,   8'hff, 8'h00, "t6_async_ovf");
        expect_at(9, 1, S_REQ,   8'hff, 8'h00, "t6_async_req_t4");
        expect_at(14, 0, S_REQ,  8'hff, 8'h00, "t6_stray_req_c14");
        expect_at(15, 0, S_REQ,  8'hff, 8'h00, "t6_stray_req_c15");
        expect_at(15, 0, S_START, 8'hff, 8'h00, "t6_stray_start");
        drive(5, 8'h60, 8'h00, 8'h00, 8'h00);
        drive(6, 8'h60, 8'h00, 8'h00, 8'h00);
        at(9);
        #1;
        rst_n = 1'b0;
        at(11);
        rst_n = 1'b1;
        drive(13, 8'h00, 8'h20, 8'h00, 8'h00);
        at(17);

        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
